// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer.
// Optional feature macro: CNN_SEQ_PERF_EN (adds the perf_cycles counter).
package cnn_seq_pkg;

    // FSM encoding kept as plain constants so older tools and dumps decode it the same way.
    typedef logic [2:0] seq_state_t;

    localparam seq_state_t IDLE  = 3'd0;
    localparam seq_state_t ISSUE = 3'd1;
    localparam seq_state_t WAIT  = 3'd2;
    localparam seq_state_t WRITE = 3'd3;
    localparam seq_state_t CLEAR = 3'd4;
    localparam seq_state_t DONE  = 3'd5;

    // Setting-register condition codes.
    localparam logic [1:0] SET_READY = 2'b11;
    localparam logic [1:0] SET_CLEAR = 2'b00;

    function automatic logic state_is_busy(input seq_state_t s);
        return (s == ISSUE) || (s == WAIT) || (s == WRITE) || (s == CLEAR);
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, setting register, PE array and output buffer.
// Optional feature macro: CNN_SEQ_PERF_EN (adds perf_cycles).
interface cnn_layer_sequencer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [1:0]        setting_done_condition;
    logic              pe_start;
    logic [ADDR_W-1:0] pe_base_addr;
    logic              pe_done;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_addr;
    logic              set_clr_signal;
    logic [1:0]        set_clr_data;
    logic              busy;
    logic              layer_done;
`ifdef CNN_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    // Sequencer side.
    modport master (
        input  setting_done_condition, pe_done,
        output pe_start, pe_base_addr, out_wr_en, out_addr,
        output set_clr_signal, set_clr_data, busy, layer_done
`ifdef CNN_SEQ_PERF_EN
        , output perf_cycles
`endif
    );

    // Environment side (setting register, PE array, output buffer).
    modport slave (
        output setting_done_condition, pe_done,
        input  pe_start, pe_base_addr, out_wr_en, out_addr,
        input  set_clr_signal, set_clr_data, busy, layer_done
`ifdef CNN_SEQ_PERF_EN
        , input perf_cycles
`endif
    );

endinterface

// File: rtl/cnn_pixel_counter.sv
// Output-pixel row/col walker with incrementally maintained input and output addresses.
// Addresses are built by adds only: +1 per column, and +KSIZE on a row wrap for the input
// window base (skipping the KSIZE-1 columns that have no full window).
module cnn_pixel_counter #(
    parameter int unsigned OUT_W  = 26,
    parameter int unsigned OUT_H  = 26,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic              last_o,
    output logic [ADDR_W-1:0] base_addr_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic              col_last;
    logic              row_last;

    assign col_last = (col_q == ADDR_W'(OUT_W - 1));
    assign row_last = (row_q == ADDR_W'(OUT_H - 1));

    // Next position: clear wins over advance; a column wrap moves to the next row.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        oaddr_d = oaddr_q;
        if (clear_i) begin
            row_d   = '0;
            col_d   = '0;
            base_d  = '0;
            oaddr_d = '0;
        end else if (advance_i) begin
            oaddr_d = oaddr_q + ADDR_W'(1);
            if (col_last) begin
                col_d  = '0;
                row_d  = row_q + ADDR_W'(1);
                base_d = base_q + ADDR_W'(KSIZE);
            end else begin
                col_d  = col_q + ADDR_W'(1);
                base_d = base_q + ADDR_W'(1);
            end
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
            oaddr_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            oaddr_q <= oaddr_d;
        end
    end

    assign last_o      = col_last && row_last;
    assign base_addr_o = base_q;
    assign out_addr_o  = oaddr_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Walks every output pixel of one conv layer once image and weights are loaded, then clears
// the setting register and pulses layer_done. All outputs are decoded from registered state.
// Optional feature macro: CNN_SEQ_PERF_EN (adds a saturating busy-cycle counter, perf_cycles).
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cnn_layer_sequencer_if.master  bus
);

    localparam int unsigned OUT_W = IMG_W - KSIZE + 1;
    localparam int unsigned OUT_H = IMG_H - KSIZE + 1;

    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("cnn_layer_sequencer: IMG_W*IMG_H does not fit in ADDR_W bits");
    end
    if ((KSIZE > IMG_W) || (KSIZE > IMG_H)) begin : g_bad_ksize
        $error("cnn_layer_sequencer: KSIZE larger than the feature map");
    end

    seq_state_t        state_q, state_d;
    logic              cnt_clear;
    logic              cnt_advance;
    logic              cnt_last;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] out_addr;

    cnn_pixel_counter #(
        .OUT_W  (OUT_W),
        .OUT_H  (OUT_H),
        .KSIZE  (KSIZE),
        .ADDR_W (ADDR_W)
    ) u_pixel_counter (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (cnt_clear),
        .advance_i   (cnt_advance),
        .last_o      (cnt_last),
        .base_addr_o (base_addr),
        .out_addr_o  (out_addr)
    );

    // Next-state and counter control; the counter is rewound at start and after the last pixel.
    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        start       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.setting_done_condition == SET_READY) begin
                    state_d   = ISSUE;
                    cnt_clear = 1'b1;
                    start     = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.pe_done) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt_last) begin
                    state_d   = CLEAR;
                    cnt_clear = 1'b1;
                end else begin
                    state_d     = ISSUE;
                    cnt_advance = 1'b1;
                end
            end
            CLEAR:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pe_start       = (state_q == ISSUE);
    assign bus.pe_base_addr   = base_addr;
    assign bus.out_wr_en      = (state_q == WRITE);
    assign bus.out_addr       = out_addr;
    assign bus.set_clr_signal = (state_q == CLEAR);
    assign bus.set_clr_data   = SET_CLEAR;
    assign bus.busy           = state_is_busy(state_q);
    assign bus.layer_done     = (state_q == DONE);

`ifdef CNN_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle count: zeroed on start, saturating, held while idle.
    always_comb begin
        perf_d = perf_q;
        if (start) begin
            perf_d = '0;
        end else if (state_is_busy(state_q) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Perf counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_cycles = perf_q;
`else
    logic unused_start;
    assign unused_start = start;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer on a 4x4 map with a 3x3 kernel.
// Build with CNN_SEQ_PERF_EN defined to also check perf_cycles.
module tb_cnn_layer_sequencer;

    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 4;
    localparam int unsigned KSIZE  = 3;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned OUT_W  = IMG_W - KSIZE + 1;
    localparam int unsigned OUT_H  = IMG_H - KSIZE + 1;
    localparam int          NPIX   = OUT_W * OUT_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_base_q[$];
    int   exp_out_q[$];

    cnn_layer_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    cnn_layer_sequencer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .KSIZE  (KSIZE),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [38:0] outs;
        bus.setting_done_condition = 2'b00;
        bus.pe_done = 1'b0;
        rst = 1'b1;
        #1;
        outs = {bus.pe_start, bus.out_wr_en, bus.set_clr_signal, bus.busy, bus.layer_done,
                bus.set_clr_data, bus.pe_base_addr, bus.out_addr};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
`ifdef CNN_SEQ_PERF_EN
        checks++;
        if (bus.perf_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d, want 0", bus.perf_cycles);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            outs = {bus.pe_start, bus.out_wr_en, bus.set_clr_signal, bus.busy, bus.layer_done,
                    bus.set_clr_data, bus.pe_base_addr, bus.out_addr};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d: got %h, want 0", i, outs);
            end
        end
    endtask

    // Runs one layer from a start already requested; pe_done arrives in WAIT cycle d.
    // With stray set, pe_done is also pulsed during ISSUE and WRITE.
    task automatic run_layer(input int d, input bit stray, input string tag);
        int cyc = 0;
        int first_start = -1;
        int clr_cyc = -1;
        int done_cyc = -1;
        int starts = 0;
        int writes = 0;
        int clrs = 0;
        int dones = 0;
        int cnt = 0;
        int e;
        bit pending = 1'b0;
        for (int r = 0; r < OUT_H; r++) begin
            for (int c = 0; c < OUT_W; c++) begin
                exp_base_q.push_back(r * IMG_W + c);
                exp_out_q.push_back(r * OUT_W + c);
            end
        end
        while (dones == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.pe_start) begin
                starts++;
                if (first_start < 0) first_start = cyc;
                checks++;
                if (exp_base_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_pe_start: got start at cycle %0d, want none", tag, cyc);
                end else begin
                    e = exp_base_q.pop_front();
                    if (bus.pe_base_addr !== ADDR_W'(e)) begin
                        errors++;
                        $display("FAIL %s pe_base_addr: got %0d, want %0d", tag, bus.pe_base_addr, e);
                    end
                end
            end
            if (bus.out_wr_en) begin
                writes++;
                checks++;
                if (exp_out_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_write: got write at cycle %0d, want none", tag, cyc);
                end else begin
                    e = exp_out_q.pop_front();
                    if (bus.out_addr !== ADDR_W'(e)) begin
                        errors++;
                        $display("FAIL %s out_addr: got %0d, want %0d", tag, bus.out_addr, e);
                    end
                end
            end
            if (bus.set_clr_signal) begin
                clrs++;
                clr_cyc = cyc;
                checks++;
                if (bus.set_clr_data !== 2'b00) begin
                    errors++;
                    $display("FAIL %s set_clr_data: got %b, want 00", tag, bus.set_clr_data);
                end
                bus.setting_done_condition = 2'b00;
            end
            if (bus.layer_done) begin
                dones++;
                done_cyc = cyc;
            end
            bus.pe_done = 1'b0;
            if (bus.pe_start) begin
                pending = 1'b1;
                cnt = d;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    bus.pe_done = 1'b1;
                    pending = 1'b0;
                end
            end
            if (stray && (bus.pe_start || bus.out_wr_en)) bus.pe_done = 1'b1;
        end
        bus.pe_done = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s layer_done_seen: got %0d, want 1", tag, dones);
        end
        checks++;
        if (first_start != 1) begin
            errors++;
            $display("FAIL %s start_latency: got %0d, want 1", tag, first_start);
        end
        checks++;
        if (starts != NPIX || writes != NPIX) begin
            errors++;
            $display("FAIL %s counts: got starts=%0d writes=%0d, want %0d each", tag, starts, writes,
                     NPIX);
        end
        checks++;
        if (clrs != 1 || clr_cyc != done_cyc - 1) begin
            errors++;
            $display("FAIL %s clear: got clrs=%0d at %0d, want 1 at %0d", tag, clrs, clr_cyc,
                     done_cyc - 1);
        end
        checks++;
        if (done_cyc != NPIX * (2 + d) + 2) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, want %0d", tag, done_cyc, NPIX * (2 + d) + 2);
        end
        checks++;
        if (exp_base_q.size() != 0 || exp_out_q.size() != 0) begin
            errors++;
            $display("FAIL %s scoreboard_left: got %0d/%0d, want 0/0", tag, exp_base_q.size(),
                     exp_out_q.size());
        end
        exp_base_q.delete();
        exp_out_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.pe_start, bus.busy, bus.layer_done, bus.set_clr_signal} !== 4'b0000) begin
                errors++;
                $display("FAIL %s post_idle %0d: got start=%b busy=%b done=%b clr=%b, want 0", tag, i,
                         bus.pe_start, bus.busy, bus.layer_done, bus.set_clr_signal);
            end
`ifdef CNN_SEQ_PERF_EN
            checks++;
            if (bus.perf_cycles !== 32'(NPIX * (2 + d) + 1)) begin
                errors++;
                $display("FAIL %s perf_cycles: got %0d, want %0d", tag, bus.perf_cycles,
                         NPIX * (2 + d) + 1);
            end
`endif
        end
    endtask

    task automatic test_layer();
        @(negedge clk);
        bus.setting_done_condition = 2'b11;
        run_layer(1, 1'b0, "layer");
    endtask

    task automatic test_ignored_cond();
        logic [1:0] vals [2];
        vals[0] = 2'b01;
        vals[1] = 2'b10;
        foreach (vals[k]) begin
            @(negedge clk);
            bus.setting_done_condition = vals[k];
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                checks++;
                if (bus.pe_start !== 1'b0 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL cond_%b: got start=%b busy=%b, want 0/0", vals[k], bus.pe_start,
                             bus.busy);
                end
            end
        end
        bus.setting_done_condition = 2'b00;
    endtask

    task automatic test_pe_done_delay();
        @(negedge clk);
        bus.setting_done_condition = 2'b11;
        run_layer(5, 1'b1, "delay_stray");
    endtask

    task automatic test_reset_midop();
        int  starts = 0;
        int  cyc = 0;
        int  e;
        bit  prev_start = 1'b0;
        logic [38:0] outs;
        exp_base_q.push_back(0);
        exp_base_q.push_back(1);
        @(negedge clk);
        bus.setting_done_condition = 2'b11;
        while (starts < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            bus.pe_done = prev_start;
            prev_start = bus.pe_start;
            if (bus.pe_start) begin
                starts++;
                e = exp_base_q.pop_front();
                checks++;
                if (bus.pe_base_addr !== ADDR_W'(e)) begin
                    errors++;
                    $display("FAIL midop_base: got %0d, want %0d", bus.pe_base_addr, e);
                end
            end
        end
        bus.pe_done = 1'b0;
        @(negedge clk);
        checks++;
        if (starts != 2 || bus.busy !== 1'b1 || bus.pe_start !== 1'b0) begin
            errors++;
            $display("FAIL midop_in_wait: got starts=%0d busy=%b start=%b, want 2/1/0", starts,
                     bus.busy, bus.pe_start);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            outs = {bus.pe_start, bus.out_wr_en, bus.set_clr_signal, bus.busy, bus.layer_done,
                    bus.set_clr_data, bus.pe_base_addr, bus.out_addr};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL midop_reset_outputs %0d: got %h, want 0", i, outs);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        run_layer(1, 1'b0, "restart");
    endtask

    initial begin
        test_reset();
        test_layer();
        test_ignored_cond();
        test_pe_done_delay();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
